stopwatch_lap: RTL



---
 rtl/stopwatch_pkg.sv | 18 +
 rtl/sw_mod_counter.sv | 26 ++
 rtl/stopwatch_lap.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state type and time-field constants for stopwatch_lap
package stopwatch_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } sw_state_t;

    localparam int MSEC_MAX = 99;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;

    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;

endpackage

// File: rtl/sw_mod_counter.sv
// rtl/sw_mod_counter.sv - modulo-(MAX+1) counter stage with carry-out for the time cascade
module sw_mod_counter #(
    parameter int WIDTH = 7,
    parameter int MAX   = 99
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             carry
);

    // carry is combinational so the whole cascade advances on the same tick edge
    assign carry = inc && (cnt == WIDTH'(MAX));

    // count on inc, wrap at MAX; hold otherwise so a forced preload sticks
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= (cnt == WIDTH'(MAX)) ? '0 : cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/stopwatch_lap.sv
// rtl/stopwatch_lap.sv - run/stop/clear stopwatch with tick divider, time cascade and lap hold (SW_LAP_EN)
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100,
    parameter int HOUR_W      = 5,
    parameter int HOUR_MAX    = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_runstop,
    input  logic              btn_clear,
    input  logic              btn_lap,
    output logic [MSEC_W-1:0] msec,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic              o_running,
    output logic              o_lap_hold,
    output logic              o_wrap
);

    localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    sw_state_t         state;
    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic              clr;

    logic [MSEC_W-1:0] live_msec;
    logic [SEC_W-1:0]  live_sec;
    logic [MIN_W-1:0]  live_min;
    logic [HOUR_W-1:0] live_hour;
    logic              msec_carry;
    logic              sec_carry;
    logic              min_carry;
    logic              hour_carry;

    assign clr       = (state == CLEAR);
    assign o_running = (state == RUN);
    assign tick      = (state == RUN) && (div_cnt == DIV_W'(DIV - 1));

    // control FSM: clear beats run/stop in STOP, CLEAR always returns to STOP
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STOP;
        end else begin
            case (state)
                STOP: begin
                    if (btn_clear) begin
                        state <= CLEAR;
                    end else if (btn_runstop) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (btn_runstop) begin
                        state <= STOP;
                    end
                end
                CLEAR:   state <= STOP;
                default: state <= STOP;
            endcase
        end
    end

    // tick divider: advances only in RUN and holds its phase across a stop
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            div_cnt <= '0;
        end else if (state == RUN) begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        end
    end

    sw_mod_counter #(.WIDTH(MSEC_W), .MAX(MSEC_MAX)) u_msec (
        .clk(clk), .rst(rst), .clr(clr), .inc(tick),
        .cnt(live_msec), .carry(msec_carry)
    );

    sw_mod_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk(clk), .rst(rst), .clr(clr), .inc(msec_carry),
        .cnt(live_sec), .carry(sec_carry)
    );

    sw_mod_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk(clk), .rst(rst), .clr(clr), .inc(sec_carry),
        .cnt(live_min), .carry(min_carry)
    );

    sw_mod_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk(clk), .rst(rst), .clr(clr), .inc(min_carry),
        .cnt(live_hour), .carry(hour_carry)
    );

    // wrap pulse lands in the same cycle the all-zero value becomes visible
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            o_wrap <= 1'b0;
        end else begin
            o_wrap <= hour_carry;
        end
    end

`ifdef SW_LAP_EN
    logic              lap_hold;
    logic [MSEC_W-1:0] snap_msec;
    logic [SEC_W-1:0]  snap_sec;
    logic [MIN_W-1:0]  snap_min;
    logic [HOUR_W-1:0] snap_hour;

    // lap hold: capture pre-increment live values on entry, release on the next press
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lap_hold  <= 1'b0;
            snap_msec <= '0;
            snap_sec  <= '0;
            snap_min  <= '0;
            snap_hour <= '0;
        end else if (btn_lap) begin
            if (state == RUN) begin
                if (!lap_hold) begin
                    snap_msec <= live_msec;
                    snap_sec  <= live_sec;
                    snap_min  <= live_min;
                    snap_hour <= live_hour;
                    lap_hold  <= 1'b1;
                end else begin
                    lap_hold <= 1'b0;
                end
            end else if (state == STOP) begin
                lap_hold <= 1'b0;
            end
        end
    end

    assign o_lap_hold = lap_hold;
    assign msec       = lap_hold ? snap_msec : live_msec;
    assign sec        = lap_hold ? snap_sec  : live_sec;
    assign min        = lap_hold ? snap_min  : live_min;
    assign hour       = lap_hold ? snap_hour : live_hour;
`else
    logic unused_lap;
    assign unused_lap = btn_lap;

    assign o_lap_hold = 1'b0;
    assign msec       = live_msec;
    assign sec        = live_sec;
    assign min        = live_min;
    assign hour       = live_hour;
`endif

endmodule
